// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the two-master serial bus arbiter.
package bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RX_SELECT,
        ST_GRANT,
        ST_ACTIVE,
        ST_READ_RETURN
    } arb_state_e;

    localparam logic MASTER_M1 = 1'b0;
    localparam logic MASTER_M2 = 1'b1;

    localparam int SLAVE_LEN_DEFAULT = 2;

endpackage

// File: rtl/bus_arbiter_if.sv
// Handshake and control signals between the two masters, the arbiter and the bus muxes.
interface bus_arbiter_if
    import bus_pkg::*;
#(
    parameter int SLAVE_LEN = SLAVE_LEN_DEFAULT
);

    logic                      m1_approval_request;
    logic                      m2_approval_request;
    logic                      m1_tx_slave_select;
    logic                      m2_tx_slave_select;
    logic                      m1_master_valid;
    logic                      m2_master_valid;
    logic                      m1_read_en;
    logic                      m2_read_en;
    logic                      slave_tx_done;
    logic                      m1_arbitor_busy;
    logic                      m2_arbitor_busy;
    logic                      m1_approval_grant;
    logic                      m2_approval_grant;
    logic                      bus_busy;
    logic                      master_sel;
    logic [(2**SLAVE_LEN)-1:0] slave_sel;

    modport slave (
        input  m1_approval_request, m2_approval_request,
        input  m1_tx_slave_select, m2_tx_slave_select,
        input  m1_master_valid, m2_master_valid,
        input  m1_read_en, m2_read_en,
        input  slave_tx_done,
        output m1_arbitor_busy, m2_arbitor_busy,
        output m1_approval_grant, m2_approval_grant,
        output bus_busy, master_sel, slave_sel
    );

    modport master (
        output m1_approval_request, m2_approval_request,
        output m1_tx_slave_select, m2_tx_slave_select,
        output m1_master_valid, m2_master_valid,
        output m1_read_en, m2_read_en,
        output slave_tx_done,
        input  m1_arbitor_busy, m2_arbitor_busy,
        input  m1_approval_grant, m2_approval_grant,
        input  bus_busy, master_sel, slave_sel
    );

endinterface

// File: rtl/bus_arbiter_serial_select_rx.sv
// Serial slave-select receiver: LSB-first bit counter plus shift register.
module serial_select_rx
    import bus_pkg::*;
#(
    parameter int SLAVE_LEN = SLAVE_LEN_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_load,
    input  logic                 i_shift,
    input  logic                 i_bit,
    output logic [SLAVE_LEN-1:0] o_index,
    output logic                 o_done
);

    localparam int CNT_W = $clog2(SLAVE_LEN + 1);

    logic [CNT_W-1:0]     r_cnt;
    logic [SLAVE_LEN-1:0] r_index;

    // Load captures bit0 and points the counter at bit1; shift fills index[cnt].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_index <= '0;
        end else if (i_load) begin
            r_index <= SLAVE_LEN'(i_bit);
            r_cnt   <= CNT_W'(1);
        end else if (i_shift) begin
            for (int i = 0; i < SLAVE_LEN; i++) begin
                if (r_cnt == CNT_W'(i)) begin
                    r_index[i] <= i_bit;
                end
            end
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_index = r_index;
    assign o_done  = (r_cnt == CNT_W'(SLAVE_LEN - 1));

endmodule

// File: rtl/bus_arbiter.sv
// Two-master bus arbiter: picks a winner, receives its serial slave select, grants and holds the bus.
// Optional feature macro ROUND_ROBIN_EN: ties alternate between masters instead of m1 always winning.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int SLAVE_LEN = SLAVE_LEN_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    bus_arbiter_if.slave  bus
);

    localparam int SLAVE_NUM = 2 ** SLAVE_LEN;

    arb_state_e           r_state;
    arb_state_e           w_state_next;
    logic                 r_owner;
    logic                 r_master_sel;
    logic                 r_seen_valid;
    logic                 r_rd;
    logic                 w_any_req;
    logic                 w_tie_winner;
    logic                 w_winner;
    logic                 w_rx_src;
    logic                 w_rx_bit;
    logic                 w_valid;
    logic                 w_read_en;
    logic                 w_load;
    logic                 w_shift;
    logic                 w_rx_done;
    logic [SLAVE_LEN-1:0] w_index;
    logic                 w_m1_busy;
    logic                 w_m2_busy;
    logic                 w_bus_busy;
    logic                 w_grant;

    assign w_any_req = bus.m1_approval_request | bus.m2_approval_request;

`ifdef ROUND_ROBIN_EN
    logic r_last_winner;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_winner <= MASTER_M2;
        end else if (r_state == ST_GRANT) begin
            r_last_winner <= r_owner;
        end
    end

    assign w_tie_winner = (r_last_winner == MASTER_M1) ? MASTER_M2 : MASTER_M1;
`else
    assign w_tie_winner = MASTER_M1;
`endif

    assign w_winner = (bus.m1_approval_request && bus.m2_approval_request) ? w_tie_winner :
                      (bus.m2_approval_request ? MASTER_M2 : MASTER_M1);

    // In IDLE the owner is not registered yet, so the serial bit comes from the live winner.
    assign w_rx_src  = (r_state == ST_IDLE) ? w_winner : r_owner;
    assign w_rx_bit  = (w_rx_src == MASTER_M2) ? bus.m2_tx_slave_select : bus.m1_tx_slave_select;
    assign w_valid   = (r_owner == MASTER_M2) ? bus.m2_master_valid : bus.m1_master_valid;
    assign w_read_en = (r_owner == MASTER_M2) ? bus.m2_read_en : bus.m1_read_en;

    serial_select_rx #(
        .SLAVE_LEN (SLAVE_LEN)
    ) u_select_rx (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load),
        .i_shift (w_shift),
        .i_bit   (w_rx_bit),
        .o_index (w_index),
        .o_done  (w_rx_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_shift      = 1'b0;
        w_m1_busy    = 1'b0;
        w_m2_busy    = 1'b0;
        w_bus_busy   = 1'b0;
        w_grant      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_load       = 1'b1;
                    w_m1_busy    = bus.m1_approval_request && (w_winner == MASTER_M2);
                    w_m2_busy    = bus.m2_approval_request && (w_winner == MASTER_M1);
                    w_state_next = (SLAVE_LEN == 1) ? ST_GRANT : ST_RX_SELECT;
                end
            end
            ST_RX_SELECT: begin
                w_shift   = 1'b1;
                w_m1_busy = (r_owner == MASTER_M2);
                w_m2_busy = (r_owner == MASTER_M1);
                if (w_rx_done) begin
                    w_state_next = ST_GRANT;
                end
            end
            ST_GRANT: begin
                w_grant      = 1'b1;
                w_bus_busy   = 1'b1;
                w_m1_busy    = (r_owner == MASTER_M2);
                w_m2_busy    = (r_owner == MASTER_M1);
                w_state_next = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                w_bus_busy = 1'b1;
                w_m1_busy  = 1'b1;
                w_m2_busy  = 1'b1;
                if (r_seen_valid && !w_valid) begin
                    w_state_next = r_rd ? ST_READ_RETURN : ST_IDLE;
                end
            end
            ST_READ_RETURN: begin
                w_bus_busy = 1'b1;
                w_m1_busy  = 1'b1;
                w_m2_busy  = 1'b1;
                if (bus.slave_tx_done) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Owner is fixed in IDLE; transaction flags are cleared on grant and tracked during ACTIVE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner      <= MASTER_M1;
            r_master_sel <= MASTER_M1;
            r_seen_valid <= 1'b0;
            r_rd         <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_owner <= w_winner;
                    end
                end
                ST_GRANT: begin
                    r_master_sel <= r_owner;
                    r_seen_valid <= 1'b0;
                    r_rd         <= 1'b0;
                end
                ST_ACTIVE: begin
                    if (w_valid) begin
                        r_seen_valid <= 1'b1;
                        r_rd         <= w_read_en;
                    end
                end
                default: ;
            endcase
        end
    end

    // Busy is gated by reset so masters already requesting during reset see all outputs at 0.
    assign bus.m1_arbitor_busy   = w_m1_busy & rst_n;
    assign bus.m2_arbitor_busy   = w_m2_busy & rst_n;
    assign bus.m1_approval_grant = w_grant && (r_owner == MASTER_M1);
    assign bus.m2_approval_grant = w_grant && (r_owner == MASTER_M2);
    assign bus.bus_busy          = w_bus_busy;
    assign bus.master_sel        = (r_state == ST_GRANT) ? r_owner : r_master_sel;
    assign bus.slave_sel         = w_bus_busy ? (SLAVE_NUM'(1) << w_index) : '0;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: grants are checked by a monitor against queued expectations.
module tb_bus_arbiter;
    import bus_pkg::*;

    typedef struct {
        logic       isM2;
        logic [3:0] sel;
        int         cycle;
    } grant_t;

    logic   clk = 1'b0;
    logic   rst_n;
    int     cyc = 0;
    int     checks = 0;
    int     errors = 0;
    grant_t expQ[$];
    grant_t expGrant;

    bus_arbiter_if #(.SLAVE_LEN(2)) bus ();

    bus_arbiter #(
        .SLAVE_LEN (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Inputs packed as {m2, m1}; drive just after the edge, leave time positioned mid-cycle.
    task automatic applyStimulus(input logic [1:0] req, input logic [1:0] tx,
                                 input logic [1:0] valid, input logic [1:0] rd, input logic done);
        @(posedge clk);
        #1;
        bus.m1_approval_request = req[0];
        bus.m2_approval_request = req[1];
        bus.m1_tx_slave_select  = tx[0];
        bus.m2_tx_slave_select  = tx[1];
        bus.m1_master_valid     = valid[0];
        bus.m2_master_valid     = valid[1];
        bus.m1_read_en          = rd[0];
        bus.m2_read_en          = rd[1];
        bus.slave_tx_done       = done;
        #3;
    endtask

    task automatic expectGrant(input logic isM2, input logic [3:0] sel);
        grant_t g;
        g.isM2  = isM2;
        g.sel   = sel;
        g.cycle = cyc + 2;
        expQ.push_back(g);
    endtask

    task automatic checkIdle(input string name);
        checkOutput(name, 32'({bus.m2_approval_grant, bus.m1_approval_grant, bus.m2_arbitor_busy,
                               bus.m1_arbitor_busy, bus.bus_busy, bus.slave_sel}), 32'd0);
    endtask

    task automatic resetDut(input string name);
        rst_n = 1'b0;
        {bus.m1_approval_request, bus.m2_approval_request, bus.m1_tx_slave_select,
         bus.m2_tx_slave_select, bus.m1_master_valid, bus.m2_master_valid,
         bus.m1_read_en, bus.m2_read_en, bus.slave_tx_done} = '0;
        #1;
        checkIdle(name);
        checkOutput({name, "MasterSel"}, 32'(bus.master_sel), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (bus.m1_approval_grant || bus.m2_approval_grant) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpectedGrant: got m1=%0b m2=%0b expected no grant (cycle %0d)",
                         bus.m1_approval_grant, bus.m2_approval_grant, cyc);
            end else begin
                expGrant = expQ.pop_front();
                checkOutput("grantM1", 32'(bus.m1_approval_grant), 32'(!expGrant.isM2));
                checkOutput("grantM2", 32'(bus.m2_approval_grant), 32'(expGrant.isM2));
                checkOutput("grantMasterSel", 32'(bus.master_sel), 32'(expGrant.isM2));
                checkOutput("grantSlaveSel", 32'(bus.slave_sel), 32'(expGrant.sel));
                checkOutput("grantBusBusy", 32'(bus.bus_busy), 32'd1);
                checkOutput("grantCycle", 32'(cyc), 32'(expGrant.cycle));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic rrWinner;

        // m1 alone writes slave 2
        resetDut("s1Reset");
        applyStimulus(2'b01, 2'b00, 2'b00, 2'b00, 1'b0);
        expectGrant(1'b0, 4'b0100);
        checkOutput("s1IdleBusy", 32'({bus.m2_arbitor_busy, bus.m1_arbitor_busy}), 32'd0);
        applyStimulus(2'b01, 2'b01, 2'b00, 2'b00, 1'b0);
        checkOutput("s1RxBusBusy", 32'(bus.bus_busy), 32'd0);
        checkOutput("s1RxM1Busy", 32'(bus.m1_arbitor_busy), 32'd0);
        applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        repeat (3) applyStimulus(2'b00, 2'b00, 2'b01, 2'b00, 1'b0);
        checkOutput("s1ActiveBusy", 32'({bus.m2_arbitor_busy, bus.m1_arbitor_busy}), 32'd3);
        applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        checkOutput("s1DropBusBusy", 32'(bus.bus_busy), 32'd1);
        applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        checkIdle("s1Release");

        // simultaneous requests: m1 slave 1, m2 slave 3
        resetDut("s2Reset");
        applyStimulus(2'b11, 2'b11, 2'b00, 2'b00, 1'b0);
        expectGrant(1'b0, 4'b0010);
        checkOutput("s2TieM2Busy", 32'(bus.m2_arbitor_busy), 32'd1);
        checkOutput("s2TieM1Busy", 32'(bus.m1_arbitor_busy), 32'd0);
        applyStimulus(2'b11, 2'b10, 2'b00, 2'b00, 1'b0);
        checkOutput("s2RxBusy", 32'({bus.m2_arbitor_busy, bus.m1_arbitor_busy}), 32'd2);
        applyStimulus(2'b10, 2'b10, 2'b00, 2'b00, 1'b0);
        checkOutput("s2GrantM2Busy", 32'(bus.m2_arbitor_busy), 32'd1);
        applyStimulus(2'b10, 2'b10, 2'b01, 2'b00, 1'b0);
        applyStimulus(2'b10, 2'b10, 2'b00, 2'b00, 1'b0);
        checkOutput("s2DropBusBusy", 32'(bus.bus_busy), 32'd1);
        applyStimulus(2'b10, 2'b10, 2'b00, 2'b00, 1'b0);
        expectGrant(1'b1, 4'b1000);
        checkIdle("s2IdleGap");
        applyStimulus(2'b10, 2'b10, 2'b00, 2'b00, 1'b0);
        applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        applyStimulus(2'b00, 2'b00, 2'b10, 2'b00, 1'b0);
        applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        checkIdle("s2Release");
        checkOutput("s2MasterSelHold", 32'(bus.master_sel), 32'd1);

        // repeated ties for slave 0: alternate under round robin, m1 always otherwise
        resetDut("s3Reset");
        for (int r = 0; r < 3; r++) begin
`ifdef ROUND_ROBIN_EN
            rrWinner = (r % 2 == 1);
`else
            rrWinner = 1'b0;
`endif
            applyStimulus(2'b11, 2'b00, 2'b00, 2'b00, 1'b0);
            expectGrant(rrWinner, 4'b0001);
            checkOutput("s3TieLoserBusy", 32'({bus.m2_arbitor_busy, bus.m1_arbitor_busy}),
                        rrWinner ? 32'd1 : 32'd2);
            applyStimulus(2'b11, 2'b00, 2'b00, 2'b00, 1'b0);
            applyStimulus(2'b11, 2'b00, 2'b00, 2'b00, 1'b0);
            applyStimulus(2'b11, 2'b00, 2'b11, 2'b00, 1'b0);
            applyStimulus(2'b11, 2'b00, 2'b00, 2'b00, 1'b0);
        end
        applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        checkIdle("s3Release");

        // m2 reads slave 3; tx_done on the valid-drop cycle is missed
        resetDut("s4Reset");
        applyStimulus(2'b10, 2'b10, 2'b00, 2'b00, 1'b0);
        expectGrant(1'b1, 4'b1000);
        applyStimulus(2'b10, 2'b10, 2'b00, 2'b00, 1'b0);
        applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        applyStimulus(2'b00, 2'b00, 2'b10, 2'b10, 1'b0);
        applyStimulus(2'b00, 2'b00, 2'b10, 2'b10, 1'b1);
        applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, 1'b1);
        checkOutput("s4DropBusBusy", 32'(bus.bus_busy), 32'd1);
        for (int i = 0; i < 9; i++) begin
            applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
            checkOutput("s4ReadHold", 32'({bus.bus_busy, bus.slave_sel}), 32'h18);
        end
        applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, 1'b1);
        checkOutput("s4DoneBusBusy", 32'(bus.bus_busy), 32'd1);
        applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        checkIdle("s4Release");

        // reset during ACTIVE, then a fresh m1 request for slave 2
        resetDut("s5Reset");
        applyStimulus(2'b01, 2'b01, 2'b00, 2'b00, 1'b0);
        expectGrant(1'b0, 4'b0010);
        applyStimulus(2'b01, 2'b00, 2'b00, 2'b00, 1'b0);
        applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        applyStimulus(2'b00, 2'b00, 2'b01, 2'b00, 1'b0);
        checkOutput("s5ActiveBusBusy", 32'(bus.bus_busy), 32'd1);
        resetDut("s5MidReset");
        applyStimulus(2'b01, 2'b00, 2'b00, 2'b00, 1'b0);
        expectGrant(1'b0, 4'b0100);
        applyStimulus(2'b01, 2'b01, 2'b00, 2'b00, 1'b0);
        applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        applyStimulus(2'b00, 2'b00, 2'b01, 2'b00, 1'b0);
        applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        checkIdle("s5Release");

        // m2 requests while m1 owns the bus (m1 slave 0, m2 slave 1)
        resetDut("s6Reset");
        applyStimulus(2'b01, 2'b00, 2'b00, 2'b00, 1'b0);
        expectGrant(1'b0, 4'b0001);
        applyStimulus(2'b01, 2'b00, 2'b00, 2'b00, 1'b0);
        applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        applyStimulus(2'b10, 2'b00, 2'b01, 2'b00, 1'b0);
        checkOutput("s6ActiveM2Busy", 32'(bus.m2_arbitor_busy), 32'd1);
        applyStimulus(2'b10, 2'b00, 2'b01, 2'b00, 1'b0);
        applyStimulus(2'b10, 2'b00, 2'b00, 2'b00, 1'b0);
        checkOutput("s6DropM2Busy", 32'(bus.m2_arbitor_busy), 32'd1);
        applyStimulus(2'b10, 2'b10, 2'b00, 2'b00, 1'b0);
        expectGrant(1'b1, 4'b0010);
        checkOutput("s6IdleM2Busy", 32'(bus.m2_arbitor_busy), 32'd0);
        applyStimulus(2'b10, 2'b00, 2'b00, 2'b00, 1'b0);
        applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        applyStimulus(2'b00, 2'b00, 2'b10, 2'b00, 1'b0);
        applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        checkIdle("s6Release");

        repeat (3) applyStimulus(2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        checkOutput("pendingGrants", 32'(expQ.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Central arbiter for the two-master serial system bus. It accepts approval requests from master 1 and master 2 and serially receives the winner's slave-select bits. It grants the bus, drives the master-mux and one-hot slave-select controls, and holds the bus until the transaction completes. It sits between the two master out ports and the bus multiplexers/slave in ports.

## Interface
- SLAVE_LEN, 2, number of serial slave-select bits; SLAVE_NUM = 2**SLAVE_LEN slaves
- clk  in  1  bus clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- m1_approval_request, m2_approval_request  in  1  bus request from each master
- m1_tx_slave_select, m2_tx_slave_select  in  1  serial slave-select bit, LSB first
- m1_master_valid, m2_master_valid  in  1  master transaction valid
- m1_read_en, m2_read_en  in  1  master read strobe (qualified by valid)
- slave_tx_done  in  1  one-cycle pulse: granted slave has finished returning read data
- m1_arbitor_busy, m2_arbitor_busy  out  1  arbiter unavailable to that master
- m1_approval_grant, m2_approval_grant  out  1  one-cycle grant pulse
- bus_busy  out  1  bus owned
- master_sel  out  1  bus mux control: 0 = m1, 1 = m2
- slave_sel  out  SLAVE_NUM  one-hot slave enable

## Operation
- States: IDLE, RX_SELECT, GRANT, ACTIVE, READ_RETURN.
- IDLE: if either request is high, pick the winner by priority. Capture the winner's bit0 this cycle. cnt=1. Go to RX_SELECT, or straight to GRANT if SLAVE_LEN=1.
- Loser indication in IDLE is combinational (Mealy). The arbitor_busy of a requesting loser is 1 in the same cycle. The winner sees 0. With no contention, both outputs are 0.
- RX_SELECT: the winner's arbitor_busy stays 0 and the loser's is 1. Shift in one bit per cycle into index[cnt]. After bit SLAVE_LEN-1, go to GRANT.
- GRANT: one cycle. The winner's approval_grant=1 and bus_busy=1 in the same cycle; both must be high together. master_sel=winner. slave_sel=1<<index. Go to ACTIVE.
- ACTIVE: both arbitor_busy=1 and bus_busy=1.
  - Set the seen_valid flag when the winner's master_valid is high.
  - While valid is high, latch rd = winner read_en.
  - When seen_valid=1 and valid=0: if rd=1 go to READ_RETURN, else go to IDLE.
- READ_RETURN: bus held. On slave_tx_done=1, go to IDLE.
- Leaving to IDLE: bus_busy, slave_sel and arbitor_busy clear. master_sel holds its last value.
- Requests from the non-owner outside IDLE are ignored. The master keeps the request asserted, and it is evaluated in IDLE.

## Timing
- Reset values: all outputs 0. State IDLE, cnt 0, index 0, seen_valid 0, rd 0. Priority pointer = m2 last winner.
- Reset mid-transaction: immediate return to reset values. No grant pulse is emitted.
- Request with bit0 in cycle T: bits are sampled in T..T+SLAVE_LEN-1, grant in T+SLAVE_LEN, ACTIVE from T+SLAVE_LEN+1.
- Release to next grant: at least one IDLE cycle. A request present on the release edge is sampled in the following IDLE cycle.
- Simultaneous requests: priority decides. The loser is blocked in that same cycle.
- slave_tx_done outside READ_RETURN is ignored.
- A valid drop and slave_tx_done in the same ACTIVE cycle still go to READ_RETURN for a read. The pulse is missed, so READ_RETURN waits for the next slave_tx_done.

## Configuration
- ROUND_ROBIN_EN defined:
  - A tie goes to the master that did not win last.
  - The pointer updates in GRANT.
  - With the reset pointer, m1 wins the first tie.
- ROUND_ROBIN_EN undefined: fixed priority, m1 always wins ties. The pointer register is not built.

## Structure
- Package bus_pkg:
  - arbiter state enum
  - MASTER_M1=1'b0 and MASTER_M2=1'b1 encodings
  - SLAVE_LEN default constant
- Sub-module serial_select_rx: bit counter plus shift register with load/shift/done. bus_arbiter muxes the winner's serial bit into it.

## Test plan
- m1 only requests slave 2 (bits 0 then 1), write: grant at T+2, slave_sel=0100, master_sel=0. Valid high 3 cycles then low, after which bus_busy goes low the next cycle.
- Both request in the same cycle, fixed priority: m2_arbitor_busy=1 in the same cycle, m1 granted. After m1 releases, m2 is granted after one IDLE cycle with master_sel=1.
- Under ROUND_ROBIN_EN, repeated simultaneous requests: grants alternate m1, m2, m1.
- m2 read of slave 3: bus_busy stays high after valid drops. It clears the cycle after the slave_tx_done pulse, which arrives 10 cycles later.
- Reset asserted low during ACTIVE: all outputs 0 immediately. A fresh m1 request is then granted at T+2.
- m2 requests during m1's ACTIVE: m2_arbitor_busy=1 and no m2 grant until m1 releases.
